hack_program_loader: RTL and testbench
======================================

Name: hack_program_loader

Overview:
- Instruction-side partner of the Hack CPU: owns instruction memory and drives the CPU's `inst` and `reset` inputs.
- Receives a program as a byte stream over a valid/ready interface (from a UART receiver) and writes it into an internal word RAM.
- Holds the CPU in reset while loading, then releases it and serves `inst = mem[pc]` combinationally, the way the Hack ROM is read.

Parameters:
- ADDR_WIDTH, 8, word address width; memory depth DEPTH = 2**ADDR_WIDTH words of 16 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle. A transfer is rx_valid && rx_ready at the rising edge.
- reload  input  1  single-cycle request to load a new program; honoured only in RUN.
- pc  input  16  CPU program counter.
- inst  output  16  instruction to the CPU.
- cpu_reset  output  1  drives the CPU reset input (registered).
- loaded_words  output  ADDR_WIDTH+1  number of words written in the current load.
- running  output  1  high in RUN.
- error  output  1  high in ERR.

Behaviour:
- States: CNT_HI, CNT_LO, WRD_HI, WRD_LO, RUN, ERR.
- Reset:
  - Next state is CNT_HI.
  - cpu_reset=1, loaded_words=0, word count register=0, hi-byte holding register=0, error=0, running=0.
  - Memory contents are not cleared.
- Load frame, big-endian:
  - Two count bytes form N (16 bit).
  - Then N words follow, each sent high byte then low byte.
- rx_ready is 1 in CNT_HI, CNT_LO, WRD_HI and WRD_LO; it is 0 in RUN and ERR. Bytes are consumed only on a transfer; without rx_valid the state holds indefinitely.
- CNT_HI: on transfer, latch N[15:8] and go to CNT_LO.
- CNT_LO: on transfer, latch N[7:0], then branch on the full N:
  - N == 0: go to RUN.
  - N > DEPTH: go to ERR.
  - Otherwise: go to WRD_HI.
- WRD_HI: on transfer, latch the byte into the holding register and go to WRD_LO.
- WRD_LO: on transfer, write {hold, rx_data} to mem[loaded_words] at that edge and increment loaded_words. If the new loaded_words == N, go to RUN; else go to WRD_HI.
- RUN:
  - running=1.
  - reload=1 goes to CNT_HI at the next edge, clears loaded_words, and sets cpu_reset=1 at that same edge.
  - rx_valid is ignored.
- ERR:
  - error=1, cpu_reset=1.
  - Exit only via reset; reload is ignored.
- cpu_reset is a register:
  - It is set to 1 at every edge where the next state is not RUN.
  - It is cleared at the first edge after the state has become RUN. cpu_reset therefore stays high for exactly one cycle while state==RUN, so the CPU samples reset with the complete program present and its PC starts at 0.
- inst (combinational):
  - When cpu_reset==0: mem[pc[ADDR_WIDTH-1:0]] if pc < DEPTH, else 16'h0000.
  - When cpu_reset==1: 16'h0000.
  - Words at addresses >= N keep their prior contents.
- loaded_words never exceeds N; N is at most DEPTH in any accepted load, so the counter cannot wrap.
- Reset mid-load abandons the partial program: words already written remain, and the state machine restarts at CNT_HI.
- reload asserted while loading is ignored.

Test Plan:
- Reset, then send 00 03 | EC 10 | E3 08 | 00 07 → mem[0..2] = EC10, E308, 0007; loaded_words=3; state=RUN. cpu_reset falls exactly one cycle after running rises. With pc=1 → inst=E308; with pc=3 → inst=prior contents of mem[3].
- Same frame with rx_valid gapped 0–3 idle cycles between bytes → identical memory contents, no extra writes, rx_ready held 1 throughout.
- ADDR_WIDTH=8, count 01 01 (257) → ERR, error=1, rx_ready=0, cpu_reset=1. Further bytes are not consumed; reload has no effect; reset returns to CNT_HI with error=0.
- Count 00 00 → RUN after 2 bytes; cpu_reset drops one cycle later; inst = existing mem[pc]; pc=16'h0100 (beyond DEPTH) → inst=0000.
- In RUN, pulse reload → cpu_reset=1 at the next edge and inst=0000. Load 00 01 | 00 2A → mem[0]=002A, mem[1] unchanged; RUN again with cpu_reset low one cycle later.
- Assert reset after 5 bytes of a 3-word load → mem[0] written, mem[1] unwritten, loaded_words=0, state=CNT_HI, cpu_reset=1.

Source files
------------

// File: rtl/hack_program_loader.sv
// hack_program_loader: receives a Hack program as a byte stream and serves it to the CPU as instruction ROM
module hack_program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  input  logic                reload,
  input  logic [15:0]         pc,
  output logic [15:0]         inst,
  output logic                cpu_reset,
  output logic [ADDR_WIDTH:0] loaded_words,
  output logic                running,
  output logic                error
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [2:0] CNT_HI = 3'd0;
  localparam logic [2:0] CNT_LO = 3'd1;
  localparam logic [2:0] WRD_HI = 3'd2;
  localparam logic [2:0] WRD_LO = 3'd3;
  localparam logic [2:0] RUN    = 3'd4;
  localparam logic [2:0] ERR    = 3'd5;
  logic [2:0] state, state_n;
  logic [15:0] cnt;
  logic [7:0] hold;
  logic [15:0] mem [DEPTH];
  logic xfer;
  logic [15:0] n_full;
  logic [ADDR_WIDTH:0] words_n;
  assign rx_ready = state < RUN;
  assign xfer = rx_valid && rx_ready;
  assign n_full = {cnt[15:8], rx_data};
  assign words_n = loaded_words + 1'b1;
  assign running = state == RUN;
  assign error = state == ERR;
  assign inst = (!cpu_reset && 32'(pc) < DEPTH) ? mem[pc[ADDR_WIDTH-1:0]] : 16'h0000;
  // frame sequencing; illegal encodings fall into ERR
  always_comb begin
    state_n = state;
    case (state)
      CNT_HI: if (xfer) state_n = CNT_LO;
      CNT_LO: if (xfer) state_n = n_full == 16'd0 ? RUN : 32'(n_full) > DEPTH ? ERR : WRD_HI;
      WRD_HI: if (xfer) state_n = WRD_LO;
      WRD_LO: if (xfer) state_n = 32'(words_n) == 32'(cnt) ? RUN : WRD_HI;
      RUN:    if (reload) state_n = CNT_HI;
      default: state_n = ERR;
    endcase
  end
  // state, count/hold latches and cpu_reset, which lingers one cycle into RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CNT_HI;
      cpu_reset <= 1'b1;
      loaded_words <= '0;
      cnt <= '0;
      hold <= '0;
    end else begin
      state <= state_n;
      cpu_reset <= !(running && state_n == RUN);
      if (xfer && state == CNT_HI) cnt[15:8] <= rx_data;
      if (xfer && state == CNT_LO) cnt[7:0] <= rx_data;
      if (xfer && state == WRD_HI) hold <= rx_data;
      if (xfer && state == WRD_LO) loaded_words <= words_n;
      if (running && reload) loaded_words <= '0;
    end
  end
  // program memory; never cleared so words beyond the current load survive
  always_ff @(posedge clk) begin
    if (!reset && xfer && state == WRD_LO) mem[loaded_words[ADDR_WIDTH-1:0]] <= {hold, rx_data};
  end
endmodule

// File: tb/tb_hack_program_loader.sv
// tb_hack_program_loader: randomized frame-level checks of the program loader against a word-array model
module tb_hack_program_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_valid = 1'b0;
  logic reload = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [15:0] pc = 16'h0000;
  logic rx_ready, cpu_reset, running, error;
  logic [15:0] inst;
  logic [8:0] loaded_words;
  logic [15:0] mem_m [256];
  logic [15:0] frame_q [$];
  logic [15:0] w0, w1;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hack_program_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reload(reload), .pc(pc), .inst(inst), .cpu_reset(cpu_reset),
    .loaded_words(loaded_words), .running(running), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    reload = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_loaded", loaded_words, 0);
    chk("rst_running", running, 0);
    chk("rst_error", error, 0);
    chk("rst_ready", rx_ready, 1);
    chk("rst_inst", inst, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) begin
      reload = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("gap_ready", rx_ready, 1);
    end
    reload = 1'b0;
    chk("ready", rx_ready, 1);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_frame(input int maxgap);
    logic [15:0] n;
    n = 16'(frame_q.size());
    send_byte(n[15:8], $urandom_range(0, maxgap));
    send_byte(n[7:0], $urandom_range(0, maxgap));
    foreach (frame_q[i]) begin
      send_byte(frame_q[i][15:8], $urandom_range(0, maxgap));
      send_byte(frame_q[i][7:0], $urandom_range(0, maxgap));
      mem_m[i] = frame_q[i];
    end
  endtask

  task automatic expect_run(input int n);
    chk("run_running", running, 1);
    chk("run_rst_hold", cpu_reset, 1);
    chk("run_inst_held", inst, 0);
    chk("run_loaded", loaded_words, n);
    chk("run_ready", rx_ready, 0);
    @(negedge clk);
    chk("run_rst_drop", cpu_reset, 0);
    chk("run_running2", running, 1);
  endtask

  task automatic verify();
    for (int p = 0; p < 256; p++) begin
      pc = 16'(p);
      #1;
      chk("inst", inst, mem_m[p]);
    end
    pc = 16'h0100;
    #1;
    chk("inst_oob", inst, 0);
    pc = 16'($urandom_range(256, 65535));
    #1;
    chk("inst_oob_rand", inst, 0);
    @(negedge clk);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("rl_cpu_reset", cpu_reset, 1);
    chk("rl_inst", inst, 0);
    chk("rl_loaded", loaded_words, 0);
    chk("rl_ready", rx_ready, 1);
    chk("rl_running", running, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    do_reset();
    frame_q = {};
    for (int i = 0; i < 256; i++) frame_q.push_back(16'($urandom));
    send_frame(0);
    expect_run(256);
    verify();
    do_reload();
    frame_q = {16'hEC10, 16'hE308, 16'h0007};
    send_frame(0);
    expect_run(3);
    pc = 16'd1;
    #1;
    chk("plan_pc1", inst, 16'hE308);
    pc = 16'd3;
    #1;
    chk("plan_pc3", inst, mem_m[3]);
    verify();
    for (int k = 0; k < 5; k++) begin
      do_reload();
      frame_q = {};
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) frame_q.push_back(16'($urandom));
      send_frame(3);
      expect_run(frame_q.size());
      verify();
    end
    do_reload();
    send_byte(8'h00, 1);
    send_byte(8'h00, 2);
    expect_run(0);
    verify();
    do_reload();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk("err_error", error, 1);
    chk("err_ready", rx_ready, 0);
    chk("err_cpu_reset", cpu_reset, 1);
    chk("err_running", running, 0);
    chk("err_inst", inst, 0);
    rx_valid = 1'b1;
    rx_data = 8'hAA;
    reload = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    reload = 1'b0;
    chk("err_stuck", error, 1);
    chk("err_loaded", loaded_words, 0);
    chk("err_cpu_reset2", cpu_reset, 1);
    do_reset();
    w0 = 16'($urandom);
    w1 = 16'($urandom);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(w0[15:8], 1);
    send_byte(w0[7:0], 0);
    send_byte(w1[15:8], 2);
    chk("mid_loaded", loaded_words, 1);
    mem_m[0] = w0;
    do_reset();
    frame_q = {16'h002A};
    send_frame(1);
    expect_run(1);
    verify();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
